// File: rtl/data_mem_responder.sv
// Data-memory responder behind the MEM stage: fixed-latency load/store service from an
// internal word array with byte/half/word lane handling and misalignment detection.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  // Latched copy of the request; the pipeline inputs are ignored once WAIT begins.
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [1:0]    lat_size;
  logic          lat_signed;
  logic          lat_read;
  logic          lat_write;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_any;
  logic          accept;
  logic [AW-1:0] idx;
  logic          misalign;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   shifted;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign req_any = req_read | req_write;
  assign accept  = (state == IDLE) && req_any;
  assign idx     = lat_addr[AW+1:2];
  assign rd_word = mem[idx];

  always_comb begin
    case (size_t'(lat_size))
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = lat_addr[0];
      default: misalign = |lat_addr[1:0];
    endcase
  end

  // Load path: right-justify the addressed lane, then sign- or zero-extend.
  always_comb begin
    shifted   = '0;
    load_data = rd_word;
    case (size_t'(lat_size))
      SZ_BYTE: begin
        shifted   = rd_word >> {lat_addr[1:0], 3'b000};
        load_data = lat_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        shifted   = rd_word >> {lat_addr[1], 4'b0000};
        load_data = lat_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end
      default: load_data = rd_word;
    endcase
  end

  // Store path: little-endian byte-lane merge into the current word.
  always_comb begin
    case (size_t'(lat_size))
      SZ_BYTE: begin
        byte_en   = 4'b0001 << lat_addr[1:0];
        wdata_rep = {4{lat_wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{lat_wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = lat_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? wdata_rep[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req_any) begin
          state_nx = WAIT;
          cnt_nx   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
    end else if (accept) begin
      lat_addr   <= req_addr[AW+1:0];
      lat_wdata  <= req_wdata;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_read   <= req_read & ~req_write;
      lat_write  <= req_write;
    end
  end

  // rdata is loaded on the edge entering RESP and otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (state == WAIT && cnt == 4'd0) begin
      rdata <= (lat_read && !misalign) ? load_data : 32'h0;
    end
  end

  // NOTE: the array is cleared by reset, so it must stay in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (state == RESP && lat_write && !misalign) begin
      mem[idx] <= merged_word;
    end
  end

  assign stall        = accept || (state == WAIT);
  assign resp_valid   = (state == RESP);
  assign misalign_err = resp_valid && misalign;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign_err;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .rdata        (rdata),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic clear_req();
    req_read   = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = 2'b10;
    req_signed = 1'b0;
  endtask

  // Drives one request from a falling edge and holds it until the response cycle ends.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                        output int stalls, output logic [31:0] d, output logic me,
                        output logic st_resp, output logic got);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd;
    req_size = sz; req_signed = sg;
    stalls = 0; got = 1'b0; d = '0; me = 1'b0; st_resp = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (resp_valid) begin
        got = 1'b1; d = rdata; me = misalign_err; st_resp = stall;
      end else if (stall) begin
        stalls++;
      end
      @(posedge clk);
      if (!got) @(negedge clk);
    end
    #1 clear_req();
  endtask

  task automatic test_reset();
    clear_req();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
  endtask

  task automatic test_first_read();
    int st; logic [31:0] d; logic me, sr, got;
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL first_read_timeout: got resp_valid %b expected 1", got); end
    vectors++; if (st != 3) begin miscompares++; $display("FAIL first_read_stalls: got %0d expected 3", st); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL first_read_data: got %h expected 00000000", d); end
    vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL first_read_resp_stall: got %b expected 0", sr); end
  endtask

  task automatic test_byte_merge();
    int st; logic [31:0] d; logic me, sr, got;
    access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL word_write_rdata: got valid %b data %h expected 1 00000000", got, d); end
    access(1'b0, 1'b1, 32'h21, 32'h00000055, 2'b00, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1 || me !== 1'b0) begin miscompares++; $display("FAIL byte_write: got valid %b misalign %b expected 1 0", got, me); end
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'hDEAD55EF) begin miscompares++; $display("FAIL byte_merge_read: got %h expected DEAD55EF", d); end
  endtask

  task automatic test_extension();
    int st; logic [31:0] d; logic me, sr, got;
    logic [31:0] a_tab [6]  = '{32'h22, 32'h22, 32'h20, 32'h23, 32'h20, 32'h22};
    logic [1:0]  sz_tab [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ex_tab [6] = '{32'hFFFFFFFF, 32'h000080FF, 32'h00000001,
                                32'h00000080, 32'h00007F01, 32'hFFFF80FF};
    access(1'b0, 1'b1, 32'h20, 32'h80FF7F01, 2'b10, 1'b0, st, d, me, sr, got);
    for (int i = 0; i < 6; i++) begin
      access(1'b1, 1'b0, a_tab[i], 32'h0, sz_tab[i], sg_tab[i], st, d, me, sr, got);
      vectors++;
      if (d !== ex_tab[i] || got !== 1'b1) begin
        miscompares++;
        $display("FAIL extension_%0d addr %h size %b signed %b: got %h expected %h", i, a_tab[i], sz_tab[i], sg_tab[i], d, ex_tab[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int st; logic [31:0] d; logic me, sr, got;
    access(1'b0, 1'b1, 32'h23, 32'h00001234, 2'b01, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1 || me !== 1'b1) begin miscompares++; $display("FAIL misalign_half_write: got valid %b misalign %b expected 1 1", got, me); end
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'h80FF7F01 || me !== 1'b0) begin miscompares++; $display("FAIL misalign_no_write: got %h misalign %b expected 80FF7F01 0", d, me); end
    access(1'b1, 1'b0, 32'h21, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'h0 || me !== 1'b1) begin miscompares++; $display("FAIL misalign_word_read: got %h misalign %b expected 00000000 1", d, me); end
    access(1'b1, 1'b0, 32'h23, 32'h0, 2'b00, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'h00000080 || me !== 1'b0) begin miscompares++; $display("FAIL byte_never_misaligned: got %h misalign %b expected 00000080 0", d, me); end
  endtask

  task automatic test_wrap_dual();
    int st; logic [31:0] d; logic me, sr, got;
    access(1'b0, 1'b1, 32'h400, 32'h11111111, 2'b10, 1'b0, st, d, me, sr, got);
    access(1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'h11111111) begin miscompares++; $display("FAIL wrap_read: got %h expected 11111111", d); end
    access(1'b1, 1'b1, 32'h30, 32'h12345678, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL dual_rdata: got valid %b data %h expected 1 00000000", got, d); end
    access(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (d !== 32'h12345678) begin miscompares++; $display("FAIL dual_store: got %h expected 12345678", d); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] d; logic me, sr, got;
    logic exp_stall [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_valid [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] d3, d7;
    d3 = '0; d7 = '0;
    access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, st, d, me, sr, got);
    access(1'b0, 1'b1, 32'h30, 32'h0BADBEEF, 2'b10, 1'b0, st, d, me, sr, got);
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h20; req_size = 2'b10;
    for (int c = 0; c < 9; c++) begin
      #1;
      vectors++;
      if (stall !== exp_stall[c] || resp_valid !== exp_valid[c]) begin
        miscompares++;
        $display("FAIL b2b_cycle_%0d: got stall %b valid %b expected stall %b valid %b", c, stall, resp_valid, exp_stall[c], exp_valid[c]);
      end
      if (c == 3) d3 = rdata;
      if (c == 7) d7 = rdata;
      @(posedge clk);
      if (c == 3) #1 req_addr = 32'h30;
      if (c == 7) #1 clear_req();
      @(negedge clk);
    end
    vectors++; if (d3 !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_first_data: got %h expected CAFEF00D", d3); end
    vectors++; if (d7 !== 32'h0BADBEEF) begin miscompares++; $display("FAIL b2b_second_data: got %h expected 0BADBEEF", d7); end
  endtask

  task automatic test_reset_abort();
    int st; logic [31:0] d; logic me, sr, got;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hAAAAAAAA; req_size = 2'b10;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL abort_in_wait: got stall %b expected 1", stall); end
    reset = 1'b1;
    clear_req();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_cycle_%0d: got valid %b stall %b expected 0 0", c, resp_valid, stall);
      end
    end
    access(1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, st, d, me, sr, got);
    vectors++; if (got !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL abort_no_write: got valid %b data %h expected 1 00000000", got, d); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_byte_merge();
    test_extension();
    test_misalign();
    test_wrap_dual();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
